// File: rtl/controlador_memoria_dados_pkg.sv
// Shared definitions for the two-port data-memory controller: state encoding,
// default memory depth and the address range test.
package memoria_pkg;

  localparam int unsigned PROF_PADRAO = 1600;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    LEITURA = 3'd1,
    ESPERA  = 3'd2,
    ESCRITA = 3'd3,
    CONCLUI = 3'd4
  } estado_t;

  // Unsigned compare: any address with the top bit set is out of range too.
  function automatic logic fora_de_faixa(input logic [31:0] endr, input int unsigned prof);
    return endr >= 32'(prof);
  endfunction

endpackage

// File: rtl/controlador_memoria_dados_seletor_rr.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the
// requester that was not granted last.
module seletor_rr (
  input  logic req0_i,
  input  logic req1_i,
  input  logic ultimo_i,
  output logic grant_o,
  output logic valid_o
);

  assign valid_o = req0_i | req1_i;
  assign grant_o = (req0_i & req1_i) ? ~ultimo_i : req1_i;

endmodule

// File: rtl/controlador_memoria_dados.sv
// Arbitrated controller giving two requesters access to one data memory.
// Every output is a register; the FSM state is exported on estado_o.
module controlador_memoria_dados
  import memoria_pkg::*;
#(
  parameter int unsigned PROF = PROF_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_0,
  input  logic        esc_0,
  input  logic [31:0] end_0,
  input  logic [31:0] dadoEscrita_0,
  output logic        ack_0,
  output logic [31:0] dadoLido_0,
  output logic        erro_0,
  input  logic        req_1,
  input  logic        esc_1,
  input  logic [31:0] end_1,
  input  logic [31:0] dadoEscrita_1,
  output logic        ack_1,
  output logic [31:0] dadoLido_1,
  output logic        erro_1,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] endereco,
  output logic [31:0] dadoEscrita,
  input  logic [31:0] dadoLido,
  output logic [2:0]  estado_o
);

  // Handshake: req_x stays high until the one-cycle ack_x pulse; the command
  // (esc/end/dadoEscrita) is captured in the OCIOSO cycle that grants it, and
  // dadoLido_x/erro_x are meaningful only while ack_x is high.
  estado_t            estado_q, estado_d;
  logic               ultimo_q, ultimo_d;
  logic               dono_q, dono_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [31:0]        endereco_q, endereco_d;
  logic [31:0]        dado_escrita_q, dado_escrita_d;
  logic [1:0]         ack_q, ack_d;
  logic [1:0]         erro_q, erro_d;
  logic [1:0][31:0]   lido_q, lido_d;

  logic               grant, valid;
  logic               sel_esc;
  logic [31:0]        sel_end, sel_dado;

  seletor_rr u_seletor (
    .req0_i   (req_0),
    .req1_i   (req_1),
    .ultimo_i (ultimo_q),
    .grant_o  (grant),
    .valid_o  (valid)
  );

  assign sel_esc  = grant ? esc_1 : esc_0;
  assign sel_end  = grant ? end_1 : end_0;
  assign sel_dado = grant ? dadoEscrita_1 : dadoEscrita_0;

  always_comb begin
    estado_d       = estado_q;
    ultimo_d       = ultimo_q;
    dono_d         = dono_q;
    mem_read_d     = 1'b0;
    mem_write_d    = 1'b0;
    endereco_d     = endereco_q;
    dado_escrita_d = dado_escrita_q;
    ack_d          = 2'b00;
    erro_d         = 2'b00;
    lido_d         = lido_q;
    case (estado_q)
      OCIOSO: begin
        if (valid) begin
          dono_d   = grant;
          ultimo_d = grant;
          if (fora_de_faixa(sel_end, PROF)) begin
            estado_d       = CONCLUI;
            ack_d[grant]   = 1'b1;
            erro_d[grant]  = 1'b1;
            lido_d[grant]  = '0;
          end else if (sel_esc) begin
            estado_d       = ESCRITA;
            mem_write_d    = 1'b1;
            endereco_d     = sel_end;
            dado_escrita_d = sel_dado;
          end else begin
            estado_d       = LEITURA;
            mem_read_d     = 1'b1;
            endereco_d     = sel_end;
          end
        end
      end
      LEITURA: estado_d = ESPERA;
      // Memory data arrives one cycle after memRead, i.e. during ESPERA.
      ESPERA: begin
        estado_d       = CONCLUI;
        ack_d[dono_q]  = 1'b1;
        lido_d[dono_q] = dadoLido;
      end
      ESCRITA: begin
        estado_d      = CONCLUI;
        ack_d[dono_q] = 1'b1;
      end
      CONCLUI: estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q       <= OCIOSO;
      ultimo_q       <= 1'b1;
      dono_q         <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      endereco_q     <= '0;
      dado_escrita_q <= '0;
      ack_q          <= 2'b00;
      erro_q         <= 2'b00;
      lido_q         <= '0;
    end else begin
      estado_q       <= estado_d;
      ultimo_q       <= ultimo_d;
      dono_q         <= dono_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      endereco_q     <= endereco_d;
      dado_escrita_q <= dado_escrita_d;
      ack_q          <= ack_d;
      erro_q         <= erro_d;
      lido_q         <= lido_d;
    end
  end

  assign memRead     = mem_read_q;
  assign memWrite    = mem_write_q;
  assign endereco    = endereco_q;
  assign dadoEscrita = dado_escrita_q;
  assign ack_0       = ack_q[0];
  assign ack_1       = ack_q[1];
  assign erro_0      = erro_q[0];
  assign erro_1      = erro_q[1];
  assign dadoLido_0  = lido_q[0];
  assign dadoLido_1  = lido_q[1];
  assign estado_o    = estado_q;

endmodule

// File: tb/tb_controlador_memoria_dados.sv
// Bench for controlador_memoria_dados: memory model, directed vector table,
// tie/reset sequences and randomized accesses against a transaction model.
module tb_controlador_memoria_dados;
  import memoria_pkg::*;

  localparam int unsigned PROF = 1600;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        req_0, esc_0, req_1, esc_1;
  logic [31:0] end_0, dadoEscrita_0, end_1, dadoEscrita_1;
  logic        ack_0, ack_1, erro_0, erro_1;
  logic [31:0] dadoLido_0, dadoLido_1;
  logic        memRead, memWrite;
  logic [31:0] endereco, dadoEscrita, dadoLido;
  logic [2:0]  estado_o;

  controlador_memoria_dados #(.PROF(PROF)) dut (
    .clock(clock), .reset(reset),
    .req_0(req_0), .esc_0(esc_0), .end_0(end_0), .dadoEscrita_0(dadoEscrita_0),
    .ack_0(ack_0), .dadoLido_0(dadoLido_0), .erro_0(erro_0),
    .req_1(req_1), .esc_1(esc_1), .end_1(end_1), .dadoEscrita_1(dadoEscrita_1),
    .ack_1(ack_1), .dadoLido_1(dadoLido_1), .erro_1(erro_1),
    .memRead(memRead), .memWrite(memWrite), .endereco(endereco),
    .dadoEscrita(dadoEscrita), .dadoLido(dadoLido), .estado_o(estado_o)
  );

  function automatic logic [31:0] valor_inicial(input int i);
    if (i == 5) return 32'hDEADBEEF;
    if (i == 1599) return 32'hCAFEF00D;
    return 32'hA5A50000 ^ (i * 32'h9E37);
  endfunction

  // ---------------- memory model ----------------
  logic [31:0] mem [0:PROF-1];
  initial begin
    for (int i = 0; i < int'(PROF); i++) mem[i] = valor_inicial(i);
    forever begin
      @(negedge clock);
      if (memWrite && endereco < PROF) mem[endereco[10:0]] = dadoEscrita;
    end
  end
  always @(posedge clock)
    if (memRead) dadoLido <= (endereco < PROF) ? mem[endereco[10:0]] : 32'h0;

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:PROF-1];
  logic [31:0] last_rd [2];
  logic [31:0] exp_q [$];

  task automatic modelo_espera(input int r, input logic esc, input logic [31:0] addr,
                               output int lat, output logic err, output logic [31:0] rd);
    if (addr >= PROF) begin lat = 1; err = 1'b1; rd = 32'h0; end
    else if (esc) begin lat = 2; err = 1'b0; rd = last_rd[r]; end
    else begin lat = 3; err = 1'b0; rd = ref_mem[addr]; end
  endtask

  task automatic modelo_atualiza(input int r, input logic esc, input logic [31:0] addr,
                                 input logic [31:0] data);
    if (addr >= PROF) last_rd[r] = 32'h0;
    else if (esc) ref_mem[addr] = data;
    else last_rd[r] = ref_mem[addr];
  endtask

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h @%0t", nome, act, exp, $time);
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic e,
                         input logic [31:0] a, input logic [31:0] d);
    if (r == 0) begin req_0 = v; esc_0 = e; end_0 = a; dadoEscrita_0 = d; end
    else begin req_1 = v; esc_1 = e; end_1 = a; dadoEscrita_1 = d; end
  endtask

  // ---------------- driver: single access ----------------
  task automatic run_access(input int r, input logic esc, input logic [31:0] addr,
                            input logic [31:0] data, input int exp_lat,
                            input logic exp_err, input logic [31:0] exp_rd);
    int lat = 0;
    int rd_cnt = 0, wr_cnt = 0, rd_cyc = 0, wr_cyc = 0;
    logic ack_r, ack_o, erro_r;
    logic [31:0] lido_r;
    @(negedge clock);
    set_req(r, 1'b1, esc, addr, data);
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(posedge clock); #1;
      // inputs after the grant must be ignored
      if (c == 1) set_req(r, 1'b1, ~esc, $urandom, $urandom);
      if (memRead) begin
        rd_cnt++; rd_cyc = c;
        chk("endereco_rd", endereco, addr);
      end
      if (memWrite) begin
        wr_cnt++; wr_cyc = c;
        chk("endereco_wr", endereco, addr);
        chk("dadoEscrita", dadoEscrita, data);
      end
      chk("rd_wr_excl", {31'b0, memRead & memWrite}, 32'd0);
      ack_r = (r == 0) ? ack_0 : ack_1;
      ack_o = (r == 0) ? ack_1 : ack_0;
      chk("ack_other", {31'b0, ack_o}, 32'd0);
      if (ack_r) begin
        lat = c;
        erro_r = (r == 0) ? erro_0 : erro_1;
        lido_r = (r == 0) ? dadoLido_0 : dadoLido_1;
        chk("erro", {31'b0, erro_r}, {31'b0, exp_err});
        chk("dadoLido", lido_r, exp_rd);
      end
    end
    chk("latency", lat, exp_lat);
    chk("memRead_cnt", rd_cnt, (!exp_err && !esc) ? 1 : 0);
    chk("memWrite_cnt", wr_cnt, (!exp_err && esc) ? 1 : 0);
    if (rd_cnt > 0) chk("memRead_cyc", rd_cyc, 1);
    if (wr_cnt > 0) chk("memWrite_cyc", wr_cyc, 1);
    // requester drops req on the edge where it samples ack
    @(posedge clock); #1;
    set_req(r, 1'b0, 1'b0, 32'h0, 32'h0);
    ack_r  = (r == 0) ? ack_0 : ack_1;
    erro_r = (r == 0) ? erro_0 : erro_1;
    lido_r = (r == 0) ? dadoLido_0 : dadoLido_1;
    chk("ack_pulse", {31'b0, ack_r}, 32'd0);
    chk("erro_idle", {31'b0, erro_r}, 32'd0);
    chk("dadoLido_hold", lido_r, exp_rd);
    chk("estado_idle", {29'b0, estado_o}, {29'b0, OCIOSO});
  endtask

  // ---------------- driver: simultaneous requests ----------------
  task automatic run_pair(input logic [31:0] a0, input logic [31:0] a1,
                          output int c0, output int c1);
    bit drop0 = 0, drop1 = 0;
    logic [31:0] e;
    c0 = 0; c1 = 0;
    @(negedge clock);
    set_req(0, 1'b1, 1'b0, a0, 32'h0);
    set_req(1, 1'b1, 1'b0, a1, 32'h0);
    for (int c = 1; c <= 20 && (c0 == 0 || c1 == 0); c++) begin
      @(posedge clock); #1;
      if (drop0) begin req_0 = 1'b0; drop0 = 0; end
      if (drop1) begin req_1 = 1'b0; drop1 = 0; end
      chk("pair_ack_excl", {31'b0, ack_0 & ack_1}, 32'd0);
      if (ack_0 || ack_1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
        chk("pair_dadoLido", ack_0 ? dadoLido_0 : dadoLido_1, e);
      end
      if (ack_0) begin c0 = c; drop0 = 1; end
      if (ack_1) begin c1 = c; drop1 = 1; end
    end
    @(posedge clock); #1;
    req_0 = 1'b0; req_1 = 1'b0;
    last_rd[0] = ref_mem[a0];
    last_rd[1] = ref_mem[a1];
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          r;
    logic        esc;
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t tab [11];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int c0, c1, acks, lat;
    logic err;
    logic [31:0] rd, a, d;
    logic e;
    int r, sel;

    tab[0]  = '{0, 1'b0, 32'd5,          32'h0,        3, 1'b0, 32'hDEADBEEF};
    tab[1]  = '{1, 1'b1, 32'd10,         32'h12345678, 2, 1'b0, 32'h00000000};
    tab[2]  = '{0, 1'b0, 32'd10,         32'h0,        3, 1'b0, 32'h12345678};
    tab[3]  = '{1, 1'b0, 32'd1600,       32'h0,        1, 1'b1, 32'h00000000};
    tab[4]  = '{0, 1'b0, 32'd1599,       32'h0,        3, 1'b0, 32'hCAFEF00D};
    tab[5]  = '{1, 1'b1, 32'hFFFFFFFF,   32'h1111,     1, 1'b1, 32'h00000000};
    tab[6]  = '{0, 1'b1, 32'd0,          32'hA0A0A0A0, 2, 1'b0, 32'hCAFEF00D};
    tab[7]  = '{1, 1'b0, 32'd0,          32'h0,        3, 1'b0, 32'hA0A0A0A0};
    tab[8]  = '{0, 1'b1, 32'd1599,       32'h0BADC0DE, 2, 1'b0, 32'hCAFEF00D};
    tab[9]  = '{1, 1'b0, 32'd1599,       32'h0,        3, 1'b0, 32'h0BADC0DE};
    tab[10] = '{0, 1'b0, 32'h80000000,   32'h0,        1, 1'b1, 32'h00000000};

    for (int i = 0; i < int'(PROF); i++) ref_mem[i] = valor_inicial(i);
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;

    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_estado", {29'b0, estado_o}, {29'b0, OCIOSO});
    chk("rst_mem_ctl", {30'b0, memRead, memWrite}, 32'd0);
    chk("rst_endereco", endereco, 32'd0);
    chk("rst_dadoEscrita", dadoEscrita, 32'd0);
    chk("rst_ack_erro", {28'b0, ack_0, ack_1, erro_0, erro_1}, 32'd0);
    chk("rst_dadoLido_0", dadoLido_0, 32'd0);
    chk("rst_dadoLido_1", dadoLido_1, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // tie straight after reset: 0 first, 1 in the OCIOSO right after
    exp_q.push_back(ref_mem[20]);
    exp_q.push_back(ref_mem[21]);
    run_pair(32'd20, 32'd21, c0, c1);
    chk("tie1_c0", c0, 3);
    chk("tie1_c1", c1, 7);
    // lone 0 access, then a tie must go to 1 first
    run_access(0, 1'b0, 32'd22, 32'h0, 3, 1'b0, ref_mem[22]);
    last_rd[0] = ref_mem[22];
    exp_q.push_back(ref_mem[24]);
    exp_q.push_back(ref_mem[23]);
    run_pair(32'd23, 32'd24, c0, c1);
    chk("tie2_c1", c1, 3);
    chk("tie2_c0", c0, 7);

    // directed table
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    for (int i = 0; i < 11; i++) begin
      run_access(tab[i].r, tab[i].esc, tab[i].addr, tab[i].data,
                 tab[i].lat, tab[i].err, tab[i].rd);
      modelo_atualiza(tab[i].r, tab[i].esc, tab[i].addr, tab[i].data);
    end

    // reset during LEITURA abandons the read
    @(negedge clock);
    set_req(0, 1'b1, 1'b0, 32'd7, 32'h0);
    @(posedge clock); #1;
    chk("rstmid_estado", {29'b0, estado_o}, {29'b0, LEITURA});
    chk("rstmid_memRead", {31'b0, memRead}, 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rstmid_estado_o", {29'b0, estado_o}, {29'b0, OCIOSO});
    chk("rstmid_ctl", {26'b0, memRead, memWrite, ack_0, ack_1, erro_0, erro_1}, 32'd0);
    chk("rstmid_addr_data", endereco | dadoEscrita, 32'd0);
    chk("rstmid_lido", dadoLido_0 | dadoLido_1, 32'd0);
    acks = 0;
    repeat (5) begin
      @(posedge clock); #1;
      if (ack_0 || ack_1) acks++;
    end
    chk("rstmid_no_ack", acks, 0);
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    run_access(0, 1'b0, 32'd7, 32'h0, 3, 1'b0, ref_mem[7]);
    modelo_atualiza(0, 1'b0, 32'd7, 32'h0);

    // randomized accesses against the transaction model
    for (int n = 0; n < 60; n++) begin
      r   = $urandom_range(0, 1);
      e   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      case (sel)
        0, 3: a = $urandom_range(0, 15);
        1:    a = $urandom_range(1594, 1605);
        default: a = $urandom;
      endcase
      d = $urandom;
      modelo_espera(r, e, a, lat, err, rd);
      run_access(r, e, a, d, lat, err, rd);
      modelo_atualiza(r, e, a, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
